// File: rtl/dtc_pkg.sv
// Shared types and defaults for the multi-channel digital-to-time converter.
// The DELAY state is used only when DTC_DELAY_EN is defined.
package dtc_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_CHANNELS = 4;
  localparam int unsigned STATE_W      = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

endpackage

// File: rtl/dtc_channel.sv
// One DTC channel: latches a code on a trig rising edge and drives a pulse exactly code cycles long.
// With DTC_DELAY_EN defined, a latched start delay inserts a DELAY phase before the pulse.
module dtc_channel
  import dtc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] code_in,
`ifdef DTC_DELAY_EN
  input  logic [WIDTH-1:0] dly_in,
`endif
  input  logic             trig,
  input  logic             abort,
  input  logic             clr_ovr,
  output logic             dtc_out,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             trig_q, trig_d;
`ifdef DTC_DELAY_EN
  logic [WIDTH-1:0] code_q, code_d;
`endif

  logic trig_rise;
  assign trig_rise = trig & ~trig_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    trig_d  = trig;
    ovr_d   = ovr_q & ~clr_ovr;
`ifdef DTC_DELAY_EN
    code_d  = code_q;
`endif
    // The done cycle still counts as busy; abort suppresses the overrun.
    if (trig && !abort && (busy_q || done_q)) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (trig_rise && !abort && !done_q) begin
`ifdef DTC_DELAY_EN
          code_d = code_in;
          if (dly_in != '0) begin
            state_d = ST_DELAY;
            cnt_d   = dly_in;
            busy_d  = 1'b1;
          end else
`endif
          if (code_in != '0) begin
            state_d = ST_ACTIVE;
            cnt_d   = code_in;
            out_d   = 1'b1;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
`ifdef DTC_DELAY_EN
      ST_DELAY: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q <= WIDTH'(1)) begin
          if (code_q != '0) begin
            state_d = ST_ACTIVE;
            cnt_d   = code_q;
            out_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
`endif
      ST_ACTIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          out_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q <= WIDTH'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          out_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        out_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      trig_q  <= 1'b0;
`ifdef DTC_DELAY_EN
      code_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      trig_q  <= trig_d;
`ifdef DTC_DELAY_EN
      code_q  <= code_d;
`endif
    end
  end

  assign dtc_out = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/dtc_multi.sv
// Multi-channel DTC top: slices the code/control buses into independent channels.
// Optional start delay (dly_in port) is enabled by defining DTC_DELAY_EN.
module dtc_multi
  import dtc_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] dtc_in,
`ifdef DTC_DELAY_EN
  input  logic [CHANNELS*WIDTH-1:0] dly_in,
`endif
  input  logic [CHANNELS-1:0]       trig,
  input  logic [CHANNELS-1:0]       abort,
  input  logic                      clr_ovr,
  output logic [CHANNELS-1:0]       dtc_out,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       overrun
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    dtc_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .rst_n   (rst),
      .code_in (dtc_in[c*WIDTH +: WIDTH]),
`ifdef DTC_DELAY_EN
      .dly_in  (dly_in[c*WIDTH +: WIDTH]),
`endif
      .trig    (trig[c]),
      .abort   (abort[c]),
      .clr_ovr (clr_ovr),
      .dtc_out (dtc_out[c]),
      .busy    (busy[c]),
      .done    (done[c]),
      .overrun (overrun[c])
    );
  end

endmodule

// File: tb/tb_dtc_multi.sv
// Directed bench for dtc_multi: pulse length, done timing, overrun, abort and async reset.
module tb_dtc_multi;
  localparam int W  = 8;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*W-1:0] dtc_in;
  logic [CH-1:0]   trig, abort;
  logic            clr_ovr;
  logic [CH-1:0]   dtc_out, busy, done, overrun;
`ifdef DTC_DELAY_EN
  logic [CH*W-1:0] dly_in;
`endif

  int tests = 0;
  int fails = 0;
  int step_n;
  int hi_cnt[CH], busy_cnt[CH], done_cnt[CH], done_at[CH], first_hi[CH];

  always #5 clk = ~clk;

  dtc_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk     (clk),
    .rst     (rst),
    .dtc_in  (dtc_in),
`ifdef DTC_DELAY_EN
    .dly_in  (dly_in),
`endif
    .trig    (trig),
    .abort   (abort),
    .clr_ovr (clr_ovr),
    .dtc_out (dtc_out),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    step_n = 0;
    for (int c = 0; c < CH; c++) begin
      hi_cnt[c] = 0; busy_cnt[c] = 0; done_cnt[c] = 0; done_at[c] = 0; first_hi[c] = 0;
    end
  endtask

  // One clock edge, then sample 1 ns later and accumulate per-channel stats.
  task automatic step();
    @(posedge clk);
    #1;
    step_n++;
    for (int c = 0; c < CH; c++) begin
      if (dtc_out[c] === 1'b1) begin
        hi_cnt[c]++;
        if (first_hi[c] == 0) first_hi[c] = step_n;
      end
      if (busy[c] === 1'b1) busy_cnt[c]++;
      if (done[c] === 1'b1) begin
        done_cnt[c]++;
        done_at[c] = step_n;
      end
    end
  endtask

  // Pulse trig for one edge on the given channels, then keep clocking.
  task automatic fire(input logic [CH-1:0] mask, input int n);
    trig = mask;
    for (int k = 0; k < n; k++) begin
      step();
      if (k == 0) trig = '0;
    end
  endtask

  task automatic set_code(input int c, input int code);
    dtc_in[c*W +: W] = W'(code);
  endtask

  initial begin
    rst = 1'b0; dtc_in = '0; trig = '0; abort = '0; clr_ovr = 1'b0;
`ifdef DTC_DELAY_EN
    dly_in = '0;
`endif
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'({dtc_out, busy, done, overrun}), 0);
    rst = 1'b1;
    step();

    // Test 2: code 5 on ch0
    set_code(0, 5); clear_stats();
    fire(4'b0001, 10);
    check("c5_first_hi", first_hi[0], 1);
    check("c5_len", hi_cnt[0], 5);
    check("c5_busy", busy_cnt[0], 5);
    check("c5_done_at", done_at[0], 6);
    check("c5_done_cnt", done_cnt[0], 1);
    check("c5_no_ovr", int'(overrun[0]), 0);

    // Minimum non-zero code
    set_code(0, 1); clear_stats();
    fire(4'b0001, 4);
    check("c1_len", hi_cnt[0], 1);
    check("c1_done_at", done_at[0], 2);

    // Test 3: ch1=255 and ch2=50 together
    set_code(1, 255); set_code(2, 50); clear_stats();
    fire(4'b0110, 260);
    check("c255_len", hi_cnt[1], 255);
    check("c255_done_at", done_at[1], 256);
    check("c50_len", hi_cnt[2], 50);
    check("c50_done_at", done_at[2], 51);
    check("c50_done_cnt", done_cnt[2], 1);
    check("xtalk_ch0", hi_cnt[0] + done_cnt[0], 0);
    check("xtalk_ch3", hi_cnt[3] + done_cnt[3], 0);

    // Test 4: code 0
    set_code(0, 0); clear_stats();
    fire(4'b0001, 4);
    check("c0_len", hi_cnt[0], 0);
    check("c0_busy", busy_cnt[0], 0);
    check("c0_done_at", done_at[0], 1);
    check("c0_done_cnt", done_cnt[0], 1);

    // Test 5: ch3 code 100, retrigger at +20
    set_code(3, 100); clear_stats();
    fire(4'b1000, 20);
    fire(4'b1000, 100);
    check("ovr_len", hi_cnt[3], 100);
    check("ovr_done_at", done_at[3], 101);
    check("ovr_set", int'(overrun[3]), 1);
    clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
    check("ovr_clear", int'(overrun[3]), 0);

    clear_stats();
    fire(4'b1000, 50);
    abort = 4'b1000; step(); abort = '0;
    check("abort_out", int'(dtc_out[3]), 0);
    check("abort_busy", int'(busy[3]), 0);
    repeat (60) step();
    check("abort_no_done", done_cnt[3], 0);

    // Abort and trig together: abort wins, no overrun
    clear_stats();
    fire(4'b1000, 5);
    trig = 4'b1000; abort = 4'b1000; step(); trig = '0; abort = '0;
    repeat (3) step();
    check("abort_trig_ovr", int'(overrun[3]), 0);
    check("abort_trig_busy", int'(busy[3]), 0);

    // Trig held high: single conversion then overrun, no restart
    set_code(0, 3); clear_stats();
    trig = 4'b0001;
    repeat (12) step();
    trig = '0;
    repeat (3) step();
    check("held_len", hi_cnt[0], 3);
    check("held_done_cnt", done_cnt[0], 1);
    check("held_ovr", int'(overrun[0]), 1);

    // Test 1: async reset mid-conversion
    set_code(0, 100); clear_stats();
    fire(4'b0001, 10);
    #2 rst = 1'b0;
    #1;
    check("rst_async_out", int'(dtc_out), 0);
    check("rst_async_all", int'({busy, done, overrun}), 0);
    step();
    #2 rst = 1'b1;
    clear_stats();
    repeat (110) step();
    check("rst_no_pulse", hi_cnt[0], 0);
    check("rst_no_done", done_cnt[0], 0);
    check("rst_no_busy", busy_cnt[0], 0);

`ifdef DTC_DELAY_EN
    // Test 6: start delay
    set_code(0, 10); dly_in[0 +: W] = W'(3); clear_stats();
    fire(4'b0001, 20);
    check("dly_first_hi", first_hi[0], 4);
    check("dly_len", hi_cnt[0], 10);
    check("dly_done_at", done_at[0], 14);
    check("dly_busy", busy_cnt[0], 13);
    set_code(0, 5); dly_in[0 +: W] = '0; clear_stats();
    fire(4'b0001, 10);
    check("dly0_first_hi", first_hi[0], 1);
    check("dly0_len", hi_cnt[0], 5);
    check("dly0_done_at", done_at[0], 6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
